// File: rtl/tx_frame_arbiter.sv
// Round-robin owner of one frame transmitter: grant -> one-cycle tx_start -> track tx_busy -> one-cycle ack.
// Requesters hold req until ack; TX_ARB_TIMEOUT_EN adds a tx_busy-rise timeout that completes with err.
module tx_frame_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 64,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [2:0]                grant_id,
  output logic                      active,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;

  localparam logic [3:0] NUM_REQ_W4 = 4'(NUM_REQ);
  localparam logic [2:0] LAST_RST   = 3'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_TIMEOUT < 1) begin : g_param_check
    $error("tx_frame_arbiter: parameter out of range");
  end

  logic [2:0]          state_q, state_d;
  logic [2:0]          last_q, last_d;
  logic [2:0]          grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                active_q, active_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [3:0]          cand;
  logic [2:0]          winner;
  logic                any_req;
  logic                timeout_hit;

  // Walk from farthest to nearest so the requester closest after last_q wins.
  always_comb begin
    winner  = last_q;
    any_req = 1'b0;
    cand    = 4'd0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = {1'b0, last_q} + 4'(off);
      if (cand >= NUM_REQ_W4) begin
        cand = cand - NUM_REQ_W4;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand == 4'(i) && req[i]) begin
          winner  = 3'(i);
          any_req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d    = S_START;
          last_d     = winner;
          grant_id_d = winner;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) begin
              tx_data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d = S_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_ACK;
        end
      end
      S_ACK:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    tx_start_d = (state_d == S_START);
    active_d   = (state_d != S_IDLE);
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_d == S_ACK) && (grant_id_d == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      grant_id_q <= 3'd0;
      ack_q      <= '0;
      active_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      active_q   <= active_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             err_q, err_d;

  // Cleared while in START so it reads zero on the first WAIT_BUSY cycle; saturates at CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_START) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT_BUSY && !tx_busy && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT_BUSY) && !tx_busy && (cnt_d == CNT_MAX);

  always_comb begin
    err_flag_d = err_flag_q;
    if (state_q == S_ACK) begin
      err_flag_d = 1'b0;
    end else if (timeout_hit) begin
      err_flag_d = 1'b1;
    end
    err_d = (state_d == S_ACK) && err_flag_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model and a cycle-stepped transmitter model.
module tb_tx_frame_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int TMO  = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [2:0]        grant_id;
  logic              active;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int m_last       = NREQ - 1;

  int busy_delay    = 2;
  int busy_len      = 20;
  bit busy_never    = 1'b0;
  int busy_fall_cyc = -1;

  logic [NREQ-1:0]    req_at_edge;
  logic [NREQ*DW-1:0] data_at_edge;

  typedef struct {
    bit                 ok;
    int                 t_start;
    int                 start_len;
    logic [2:0]         gid;
    logic [DW-1:0]      data;
    logic [NREQ-1:0]    sreq;
    logic [NREQ*DW-1:0] sdata;
    logic [NREQ-1:0]    ackv;
    logic               errv;
    int                 t_ack;
    int                 ack_len;
    bit                 stable;
    bit                 active_ok;
  } txn_t;

  tx_frame_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .grant_id(grant_id), .active(active), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    req_at_edge  <= req;
    data_at_edge <= req_data;
  end

  // Transmitter: busy rises busy_delay cycles after it sees tx_start, stays high busy_len cycles.
  initial begin
    int phase;
    int cnt;
    phase   = 0;
    cnt     = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase   = 0;
        tx_busy = 1'b0;
      end else if (phase == 0) begin
        if (tx_start === 1'b1 && !busy_never) begin
          if (busy_delay == 0) begin
            tx_busy = 1'b1;
            cnt     = busy_len;
            phase   = 2;
          end else begin
            cnt   = busy_delay;
            phase = 1;
          end
        end
      end else if (phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          tx_busy = 1'b1;
          cnt     = busy_len;
          phase   = 2;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          tx_busy       = 1'b0;
          busy_fall_cyc = cyc;
          phase         = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Collects one transaction (start to end of ack); optionally drops the acked req bit.
  task automatic observe_txn(input bit drop, output txn_t t);
    int n;
    t.ok = 0; t.t_start = -1; t.start_len = 0; t.gid = 3'd0; t.data = '0;
    t.sreq = '0; t.sdata = '0; t.ackv = '0; t.errv = 1'b0; t.t_ack = -1;
    t.ack_len = 0; t.stable = 1; t.active_ok = 1;
    n = 0;
    while (tx_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) return;
    t.t_start = cyc;
    t.gid     = grant_id;
    t.data    = tx_data;
    t.sreq    = req_at_edge;
    t.sdata   = data_at_edge;
    n = 0;
    while (ack === '0 && n < 300) begin
      if (tx_start === 1'b1) t.start_len++;
      if (tx_data !== t.data) t.stable = 0;
      if (active !== 1'b1) t.active_ok = 0;
      @(negedge clk);
      n++;
    end
    if (n >= 300) return;
    t.t_ack = cyc;
    t.ackv  = ack;
    t.errv  = err;
    if (tx_data !== t.data) t.stable = 0;
    if (active !== 1'b1) t.active_ok = 0;
    if (drop) req = req & ~ack;
    while (ack !== '0 && t.ack_len < 4) begin
      t.ack_len++;
      @(negedge clk);
    end
    t.ok = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b want 0000", ack); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
    tests_run++; if (tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", active); end
    tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    tests_run++; if (tx_data !== 64'd0) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    rst    = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic test_single();
    txn_t t;
    int   req_cyc;
    @(negedge clk);
    req_data[0 +: DW] = 64'h0123_4567_89AB_CDEF;
    req     = 4'b0001;
    req_cyc = cyc;
    observe_txn(1'b1, t);
    tests_run++; if (!t.ok) begin tests_failed++; $display("FAIL single_done: transaction did not complete"); end
    tests_run++; if (t.t_start !== req_cyc + 1) begin tests_failed++; $display("FAIL single_start_lat: got %0d want %0d", t.t_start, req_cyc + 1); end
    tests_run++; if (t.start_len !== 1) begin tests_failed++; $display("FAIL single_start_len: got %0d want 1", t.start_len); end
    tests_run++; if (t.data !== 64'h0123_4567_89AB_CDEF) begin tests_failed++; $display("FAIL single_data: got %h want 0123456789abcdef", t.data); end
    tests_run++; if (t.ackv !== 4'b0001) begin tests_failed++; $display("FAIL single_ack: got %b want 0001", t.ackv); end
    tests_run++; if (t.ack_len !== 1) begin tests_failed++; $display("FAIL single_ack_len: got %0d want 1", t.ack_len); end
    tests_run++; if (t.errv !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b want 0", t.errv); end
    tests_run++; if (t.t_ack !== busy_fall_cyc + 1) begin tests_failed++; $display("FAIL single_ack_lat: got %0d want %0d", t.t_ack, busy_fall_cyc + 1); end
    tests_run++; if (!t.stable || !t.active_ok) begin tests_failed++; $display("FAIL single_hold: stable %0d active %0d want 1 1", t.stable, t.active_ok); end
    m_last = 0;
  endtask

  task automatic test_round_robin();
    txn_t t;
    int   exp;
    int   prev_ack;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
    req      = 4'b1111;
    prev_ack = -1;
    for (int n = 0; n < 5; n++) begin
      observe_txn(1'b0, t);
      exp = rr_pick(t.sreq, m_last);
      tests_run++; if (t.gid !== 3'(exp) || exp !== n % NREQ) begin tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", n, t.gid, n % NREQ); end
      tests_run++; if (t.data !== t.sdata[exp*DW +: DW]) begin tests_failed++; $display("FAIL rr_data[%0d]: got %h want %h", n, t.data, t.sdata[exp*DW +: DW]); end
      tests_run++; if (t.ack_len !== 1) begin tests_failed++; $display("FAIL rr_ack_len[%0d]: got %0d want 1", n, t.ack_len); end
      if (n > 0) begin
        tests_run++; if (t.t_start - prev_ack !== 2) begin tests_failed++; $display("FAIL rr_gap[%0d]: got %0d want 2", n, t.t_start - prev_ack); end
      end
      prev_ack = t.t_ack;
      m_last   = exp;
    end
    req = '0;
  endtask

  task automatic test_late_arrivals();
    txn_t            t;
    logic [NREQ-1:0] acked;
    int              exp;
    bit              idle_ok;
    do_reset();
    req   = 4'b0001;
    acked = '0;
    fork
      observe_txn(1'b1, t);
      begin
        repeat (4) @(negedge clk);
        req = req | 4'b1010;
      end
    join
    acked = acked | t.ackv;
    tests_run++; if (t.gid !== 3'd0) begin tests_failed++; $display("FAIL late_first: got %0d want 0", t.gid); end
    m_last = 0;
    for (int n = 0; n < 2; n++) begin
      observe_txn(1'b1, t);
      exp = rr_pick(t.sreq, m_last);
      tests_run++; if (t.gid !== 3'(exp) || exp !== 2 * n + 1) begin tests_failed++; $display("FAIL late_order[%0d]: got %0d want %0d", n, t.gid, 2 * n + 1); end
      acked  = acked | t.ackv;
      m_last = exp;
    end
    tests_run++; if (acked[2] !== 1'b0) begin tests_failed++; $display("FAIL late_no_ack2: got %b want 0", acked[2]); end
    idle_ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || active !== 1'b0) idle_ok = 0;
    end
    tests_run++; if (!idle_ok) begin tests_failed++; $display("FAIL late_idle: got activity want none"); end
  endtask

  task automatic test_drop_mid_transfer();
    txn_t          t;
    logic [DW-1:0] d;
    int            n;
    d = {$urandom, $urandom};
    @(negedge clk);
    req_data[2*DW +: DW] = d;
    req = 4'b0100;
    fork
      observe_txn(1'b1, t);
      begin
        n = 0;
        while (tx_busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        req[2] = 1'b0;
        req_data[2*DW +: DW] = ~d;
      end
    join
    tests_run++; if (t.ackv !== 4'b0100) begin tests_failed++; $display("FAIL drop_ack: got %b want 0100", t.ackv); end
    tests_run++; if (t.data !== d || !t.stable) begin tests_failed++; $display("FAIL drop_data: got %h stable %0d want %h 1", t.data, t.stable, d); end
    tests_run++; if (t.ack_len !== 1) begin tests_failed++; $display("FAIL drop_ack_len: got %0d want 1", t.ack_len); end
    m_last = 2;
  endtask

  task automatic test_busy_early();
    txn_t t;
    busy_delay = 0;
    busy_len   = 3;
    @(negedge clk);
    req = 4'b1000;
    observe_txn(1'b1, t);
    tests_run++; if (!t.ok || t.ackv !== 4'b1000) begin tests_failed++; $display("FAIL early_ack: got %b want 1000", t.ackv); end
    tests_run++; if (t.t_ack !== busy_fall_cyc + 1) begin tests_failed++; $display("FAIL early_ack_lat: got %0d want %0d", t.t_ack, busy_fall_cyc + 1); end
    busy_delay = 2;
    busy_len   = 20;
    m_last     = 3;
  endtask

`ifdef TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    txn_t t;
    do_reset();
    busy_never = 1'b1;
    req = 4'b0001;
    observe_txn(1'b1, t);
    tests_run++; if (t.ackv !== 4'b0001 || t.errv !== 1'b1) begin tests_failed++; $display("FAIL tmo_ack_err: got %b %b want 0001 1", t.ackv, t.errv); end
    tests_run++; if (t.t_ack - t.t_start !== TMO + 1) begin tests_failed++; $display("FAIL tmo_len: got %0d want %0d", t.t_ack - t.t_start, TMO + 1); end
    busy_never = 1'b0;
    req = 4'b0010;
    observe_txn(1'b1, t);
    tests_run++; if (t.gid !== 3'd1 || t.errv !== 1'b0) begin tests_failed++; $display("FAIL tmo_next: got %0d %b want 1 0", t.gid, t.errv); end
    m_last = 1;
  endtask
`endif

  task automatic test_random();
    txn_t            t;
    int              exp;
    logic [NREQ-1:0] exp_ack;
    for (int n = 0; n < 12; n++) begin
      busy_delay = $urandom_range(0, 4);
      busy_len   = $urandom_range(2, 8);
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
      req = req | 4'($urandom_range(1, 15));
      observe_txn(1'b1, t);
      exp     = rr_pick(t.sreq, m_last);
      exp_ack = 4'b0001 << exp;
      tests_run++; if (t.gid !== 3'(exp)) begin tests_failed++; $display("FAIL rand_gid[%0d]: got %0d want %0d", n, t.gid, exp); end
      tests_run++; if (t.data !== t.sdata[exp*DW +: DW]) begin tests_failed++; $display("FAIL rand_data[%0d]: got %h want %h", n, t.data, t.sdata[exp*DW +: DW]); end
      tests_run++; if (t.ackv !== exp_ack || t.errv !== 1'b0) begin tests_failed++; $display("FAIL rand_ack[%0d]: got %b %b want %b 0", n, t.ackv, t.errv, exp_ack); end
      tests_run++; if (t.t_ack !== busy_fall_cyc + 1) begin tests_failed++; $display("FAIL rand_ack_lat[%0d]: got %0d want %0d", n, t.t_ack, busy_fall_cyc + 1); end
      tests_run++; if (t.start_len !== 1 || !t.stable) begin tests_failed++; $display("FAIL rand_start[%0d]: len %0d stable %0d want 1 1", n, t.start_len, t.stable); end
      m_last = exp;
    end
    busy_delay = 2;
    busy_len   = 20;
    while (req !== '0) begin
      observe_txn(1'b1, t);
      if (!t.ok) req = '0;
    end
  endtask

  task automatic test_reset_mid_transfer();
    txn_t t;
    int   n;
    bit   saw_ack;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
    req = 4'b0110;
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL rmid_busy_wait: busy never rose within %0d cycles", n); end
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    saw_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack !== '0) saw_ack = 1;
    end
    tests_run++; if (saw_ack) begin tests_failed++; $display("FAIL rmid_no_ack: got ack want none"); end
    tests_run++; if (active !== 1'b0 || tx_start !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL rmid_ctl: got %b%b%b want 000", active, tx_start, err); end
    tests_run++; if (grant_id !== 3'd0 || tx_data !== 64'd0) begin tests_failed++; $display("FAIL rmid_regs: got %0d %h want 0 0", grant_id, tx_data); end
    rst    = 1'b0;
    m_last = NREQ - 1;
    for (int k = 0; k < 2; k++) begin
      observe_txn(1'b1, t);
      n = rr_pick(t.sreq, m_last);
      tests_run++; if (t.gid !== 3'(n) || n !== k + 1) begin tests_failed++; $display("FAIL rmid_after[%0d]: got %0d want %0d", k, t.gid, k + 1); end
      m_last = n;
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_late_arrivals();
    test_drop_mid_transfer();
    test_busy_early();
`ifdef TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Shares one 64-bit frame transmitter between NUM_REQ requesters. It selects a requester round-robin and latches that requester's frame. It then issues a one-cycle start to the transmitter, tracks the transmitter's busy signal through the whole transfer, and returns a one-cycle acknowledge to the winner. It sits between the producer blocks and the serial transmission chain, so only one frame is ever in flight.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 64: frame width.
- START_TIMEOUT, 1024: cycles allowed for tx_busy to rise after tx_start. Used only with TX_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester request; held high until the matching ack.
- req_data  in  NUM_REQ*DATA_W  frames; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- err  out  1  one-cycle pulse coincident with ack; set when the transfer timed out.
- grant_id  out  3  index of the current or last granted requester.
- active  out  1  high from grant until ack, inclusive.
- tx_data  out  DATA_W  latched frame to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter busy; high while a frame is being sent.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE, when any req bit is high at an edge:
  - the winner g is chosen by searching from (last+1) mod NUM_REQ upward with wrap-around;
  - grant_id and last are set to g, tx_data is latched from slice g, and the FSM moves to START.
- START: tx_start = 1 for exactly this cycle. The FSM then moves to WAIT_BUSY.
- WAIT_BUSY: when tx_busy is sampled high, the FSM moves to WAIT_DONE. With TX_ARB_TIMEOUT_EN, if the counter reaches START_TIMEOUT, err_flag is set and the FSM moves to ACK.
- WAIT_DONE: when tx_busy is sampled low, the FSM moves to ACK.
- ACK: ack[g] = 1 and err = err_flag for exactly this cycle. err_flag is then cleared and the FSM returns to IDLE.
- tx_data is held constant from START through ACK. It keeps its value in IDLE and changes only on the next grant.
- Requester rules:
  - A requester drops req on the edge that ends its ack cycle.
  - If req is dropped mid-transfer, the transfer still completes and ack is still pulsed.
  - req_data is sampled only at grant.
- If tx_busy is already high in START, that is legal: WAIT_BUSY exits on the next edge.
- All outputs are registered.

## Timing
- Reset values:
  - state IDLE, last = NUM_REQ-1 (so requester 0 wins first);
  - ack = 0, err = 0, tx_start = 0, active = 0, grant_id = 0, tx_data = 0, timeout counter = 0.
- Latency from req sampled in IDLE at edge k:
  - tx_start is high during cycle k..k+1;
  - ack rises one edge after tx_busy is sampled low in WAIT_DONE.
- Minimum gap between two back-to-back grants: one IDLE cycle after ACK. A new req sampled at the edge leaving ACK is not granted until the following edge.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees each waiting requester is served within NUM_REQ transactions.
- Timeout counter:
  - width is clog2(START_TIMEOUT+1);
  - it clears on entry to WAIT_BUSY and increments each WAIT_BUSY cycle with tx_busy low;
  - it saturates and never wraps.
- Reset mid-transfer: all state and outputs return to their reset values on the next edge. No ack is issued for the aborted frame, and last returns to NUM_REQ-1.

## Configuration
- TX_ARB_TIMEOUT_EN defined: the WAIT_BUSY timeout is compiled in. If tx_busy has not risen after START_TIMEOUT cycles, the FSM takes the ACK path with err = 1.
- TX_ARB_TIMEOUT_EN undefined: the counter is removed, WAIT_BUSY waits indefinitely, and err is tied to 0.

## Test plan
- Single request: req = 4'b0001, data 64'h0123_4567_89AB_CDEF; the transmitter model asserts busy 2 cycles after start for 20 cycles. Required: tx_start high for 1 cycle, tx_data = 64'h0123_4567_89AB_CDEF, ack = 4'b0001 for 1 cycle after busy falls, err = 0.
- All four requests held continuously: grant order 0,1,2,3,0. Each ack is one cycle, and there is one idle cycle between ACK and the next START.
- Requests 1 and 3 arrive while requester 0 is being served: after 0 the order is 1 then 3; requester 2 is never acked.
- req[2] drops during WAIT_DONE: the transfer completes and ack[2] still pulses. Changing req_data after grant leaves tx_data unchanged.
- With TX_ARB_TIMEOUT_EN and START_TIMEOUT = 16, the model never asserts busy: the ack and err pulses occur together after 16 WAIT_BUSY cycles, then the next request is served.
- rst asserted during WAIT_DONE with req = 4'b0110: no ack is issued and outputs return to reset values. After release, requester 1 is granted first (last = 3).
